// File: rtl/pipeline_pkg.sv
// Shared definitions for the LI (latency-insensitive) pipeline building blocks:
// handshake polarity constants and a constant-evaluable clog2 helper.
package pipeline_pkg;

  // Level that marks a token as present on a valid line.
  localparam logic LI_VALID = 1'b1;
  // Level that marks a stall on a backpressure line.
  localparam logic LI_STALL = 1'b1;

  // Ceiling log2. Usable in parameter and localparam expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Pointer width for a ring of n slots. It is never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipeline_wrap_ctr.sv
// Modulo-Depth pointer. It wraps explicitly from Depth-1 to 0, so the ring
// size does not have to be a power of two.
module pipeline_wrap_ctr
  import pipeline_pkg::*;
#(
  parameter int Depth = 4,
  localparam int PW = ptr_width(Depth)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(Depth - 1);

  // Advance on inc and wrap at the last slot. Reset returns the pointer to slot 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_fifo_param.sv
// N-slot elastic LI buffer. It provides an occupancy count, an almost-full
// flag and an optional zero-latency bypass that is used while the buffer
// is empty. Backpressure is derived only from the registered count, so
// there is no combinational path from q_bp to d_bp.
module pipeline_fifo_param
  import pipeline_pkg::*;
#(
  parameter int Width      = 8,
  parameter int Depth      = 4,
  parameter int Bypass     = 0,
  parameter int AlmostFull = Depth - 1,
  localparam int CW = clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [Width-1:0] d,
  input  logic             d_valid,
  output logic             d_bp,
  output logic [Width-1:0] q,
  output logic             q_valid,
  input  logic             q_bp,
  output logic [CW-1:0]    count,
  output logic             almost_full
);

  localparam int            PW       = ptr_width(Depth);
  localparam logic [CW-1:0] FULL_CNT = CW'(Depth);
  localparam logic [CW-1:0] AF_CNT   = CW'(AlmostFull);

  logic [Width-1:0] mem [Depth];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             empty;
  logic             byp_now;
  logic             incoming;
  logic             outgoing;
  logic             push;
  logic             pop;

  assign empty       = (count == '0);
  assign byp_now     = (Bypass != 0) && empty;
  assign d_bp        = (count == FULL_CNT);
  assign almost_full = (count >= AF_CNT);

  assign incoming = (d_valid == LI_VALID) && (d_bp != LI_STALL);
  assign outgoing = (q_valid == LI_VALID) && (q_bp != LI_STALL);

  // When the bypass path is active and downstream takes the token, the
  // token is never stored. Otherwise every accepted token is written.
  assign push = incoming && !(byp_now && !q_bp);
  // A bypassed token leaves without being stored, so it does not pop storage.
  assign pop  = outgoing && !empty;

  // Output select: the head of storage, or the live input while bypassing.
  always_comb begin
    q       = mem[rd_ptr];
    q_valid = !empty;
    if (byp_now) begin
      q       = d;
      q_valid = d_valid;
    end
  end

  // Occupancy. A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Token storage. It is data only and is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= d;
    end
  end

  pipeline_wrap_ctr #(.Depth(Depth)) u_wr_ctr (
    .clk    (clk),
    .resetn (resetn),
    .inc    (push),
    .ptr    (wr_ptr)
  );

  pipeline_wrap_ctr #(.Depth(Depth)) u_rd_ctr (
    .clk    (clk),
    .resetn (resetn),
    .inc    (pop),
    .ptr    (rd_ptr)
  );

  a_count_bound : assert property (@(posedge clk) disable iff (!resetn)
    count <= FULL_CNT);

  a_no_push_full : assert property (@(posedge clk) disable iff (!resetn)
    !(incoming && d_bp));

  a_q_stable : assert property (@(posedge clk) disable iff (!resetn)
    (q_valid && q_bp) |=> (q == $past(q)));

endmodule

// File: tb/tb_pipeline_fifo_param.sv
// Bench for pipeline_fifo_param. Six configurations share one stimulus
// stream. Each configuration has its own list-based token model, and
// literal expectations pin the directed scenarios.
module tb_pipeline_fifo_param;

  localparam int NI = 6;

  function automatic int dep_of(input int i);
    case (i)
      0: return 4;
      1: return 3;
      2: return 4;
      3: return 1;
      4: return 2;
      default: return 5;
    endcase
  endfunction

  function automatic int byp_of(input int i);
    return (i == 2 || i == 5) ? 1 : 0;
  endfunction

  function automatic int af_of(input int i);
    return (dep_of(i) > 1) ? dep_of(i) - 1 : 1;
  endfunction

  logic       clk;
  logic       resetn;
  logic [7:0] d;
  logic       d_valid;
  logic       q_bp;

  logic [NI-1:0][7:0] q_w;
  logic [NI-1:0][3:0] cnt_w;
  logic [NI-1:0]      qv_w;
  logic [NI-1:0]      dbp_w;
  logic [NI-1:0]      af_w;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D   = dep_of(g);
    localparam int CWL = $clog2(D + 1);
    logic [CWL-1:0] c;
    logic [7:0]     qq;
    logic           qv;
    logic           bp;
    logic           af;

    pipeline_fifo_param #(
      .Width      (8),
      .Depth      (D),
      .Bypass     (byp_of(g)),
      .AlmostFull (af_of(g))
    ) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .d           (d),
      .d_valid     (d_valid),
      .d_bp        (bp),
      .q           (qq),
      .q_valid     (qv),
      .q_bp        (q_bp),
      .count       (c),
      .almost_full (af)
    );

    assign q_w[g]   = qq;
    assign qv_w[g]  = qv;
    assign dbp_w[g] = bp;
    assign af_w[g]  = af;
    assign cnt_w[g] = 4'(c);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int cyc;
  bit mvalid;

  // Model: each instance holds an ordered list of stored tokens, with the head at index 0.
  logic [7:0] mdat [NI][8];
  int         msz    [NI];
  int         outcnt [NI];
  int         lastout3;

  task automatic chk(input string nm, input int i, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s inst%0d cyc%0d got=%0h want=%0h", nm, i, cyc, got, want);
    end
  endtask

  function automatic bit m_byp_empty(input int i);
    return (byp_of(i) != 0) && (msz[i] == 0);
  endfunction

  function automatic bit m_qv(input int i);
    return m_byp_empty(i) ? d_valid : (msz[i] != 0);
  endfunction

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      chk("d_bp", i, int'(dbp_w[i]), int'(msz[i] == dep_of(i)));
      chk("count", i, int'(cnt_w[i]), msz[i]);
      chk("almost_full", i, int'(af_w[i]), int'(msz[i] >= af_of(i)));
      chk("q_valid", i, int'(qv_w[i]), int'(m_qv(i)));
      if (m_qv(i)) begin
        chk("q", i, int'(q_w[i]), int'(m_byp_empty(i) ? d : mdat[i][0]));
      end
    end
  endtask

  task automatic model_step();
    if (!resetn) begin
      for (int i = 0; i < NI; i++) msz[i] = 0;
      mvalid = 1'b1;
      return;
    end
    for (int i = 0; i < NI; i++) begin
      bit acc;
      bit out;
      bit be;
      be  = m_byp_empty(i);
      acc = d_valid && (msz[i] != dep_of(i));
      out = m_qv(i) && !q_bp;
      if (out) begin
        outcnt[i]++;
        if (i == 3) begin
          if (lastout3 >= 0) chk("d1_rate", i, int'((cyc - lastout3) >= 2), 1);
          lastout3 = cyc;
        end
      end
      if (be) begin
        if (acc && q_bp) begin
          mdat[i][0] = d;
          msz[i]     = 1;
        end
      end else begin
        if (out) begin
          for (int k = 0; k < 7; k++) mdat[i][k] = mdat[i][k+1];
          msz[i]--;
        end
        if (acc) begin
          mdat[i][msz[i]] = d;
          msz[i]++;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mvalid) check_all();
    model_step();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; mvalid = 1'b0; lastout3 = -1;
    for (int i = 0; i < NI; i++) begin msz[i] = 0; outcnt[i] = 0; end
    resetn = 1'b0; d = 8'h00; d_valid = 1'b0; q_bp = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    chk("rst_count", 0, int'(cnt_w[0]), 0);
    chk("rst_q_valid", 0, int'(qv_w[0]), 0);
    chk("rst_d_bp", 0, int'(dbp_w[0]), 0);
    chk("rst_af", 0, int'(af_w[0]), 0);

    // Fill Depth=4 with the downstream stalled.
    q_bp = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = 8'(8'h11 * (k + 1)); d_valid = 1'b1;
      tick();
      chk("fill_count", 0, int'(cnt_w[0]), k + 1);
      chk("fill_af", 0, int'(af_w[0]), int'(k + 1 >= 3));
      chk("fill_q_head", 0, int'(q_w[0]), 8'h11);
    end
    chk("full_d_bp", 0, int'(dbp_w[0]), 1);
    d_valid = 1'b0;
    tick();
    chk("stall_q", 0, int'(q_w[0]), 8'h11);
    chk("stall_count", 0, int'(cnt_w[0]), 4);

    // Drain Depth=4.
    q_bp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("drain_q", 0, int'(q_w[0]), 8'h11 * (k + 1));
      tick();
      chk("drain_count", 0, int'(cnt_w[0]), 3 - k);
      if (k == 0) chk("drain_d_bp", 0, int'(dbp_w[0]), 0);
    end
    chk("drain_q_valid", 0, int'(qv_w[0]), 0);

    // Stream through Depth=3 at full rate.
    for (int k = 0; k < 10; k++) begin
      d = 8'(k); d_valid = 1'b1;
      tick();
      chk("d3_q", 1, int'(q_w[1]), k);
      chk("d3_q_valid", 1, int'(qv_w[1]), 1);
      chk("d3_count", 1, int'(cnt_w[1]), 1);
    end
    d_valid = 1'b0;
    tick();
    chk("d3_empty", 1, int'(cnt_w[1]), 0);
    tick(); tick();

    // Bypass with an empty buffer.
    d = 8'hA5; d_valid = 1'b1; q_bp = 1'b0;
    #1;
    chk("byp_q", 2, int'(q_w[2]), 8'hA5);
    chk("byp_q_valid", 2, int'(qv_w[2]), 1);
    chk("byp_count0", 2, int'(cnt_w[2]), 0);
    tick();
    chk("byp_pass_count", 2, int'(cnt_w[2]), 0);
    q_bp = 1'b1;
    tick();
    d_valid = 1'b0; d = 8'h00;
    #1;
    chk("byp_store_count", 2, int'(cnt_w[2]), 1);
    chk("byp_store_q", 2, int'(q_w[2]), 8'hA5);
    chk("byp_store_qv", 2, int'(qv_w[2]), 1);
    tick();
    chk("byp_hold_q", 2, int'(q_w[2]), 8'hA5);
    q_bp = 1'b0;
    for (int k = 0; k < 6; k++) tick();

    // Reset in the middle of a stream.
    q_bp = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      d = 8'(k); d_valid = 1'b1;
      tick();
    end
    chk("mid_count", 0, int'(cnt_w[0]), 3);
    resetn = 1'b0; d_valid = 1'b0;
    tick();
    chk("mid_rst_count", 0, int'(cnt_w[0]), 0);
    chk("mid_rst_qv", 0, int'(qv_w[0]), 0);
    chk("mid_rst_d_bp", 0, int'(dbp_w[0]), 0);
    resetn = 1'b1; q_bp = 1'b0; d = 8'h7E; d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    chk("post_rst_q", 0, int'(q_w[0]), 8'h7E);
    chk("post_rst_qv", 0, int'(qv_w[0]), 1);
    tick();
    chk("post_rst_empty", 0, int'(cnt_w[0]), 0);

    // Random stress on valid and backpressure.
    begin
      int start;
      start = outcnt[3];
      for (int n = 0; n < 40000 && (outcnt[3] - start) < 2000; n++) begin
        d_valid = 1'($urandom_range(0, 1));
        q_bp    = 1'($urandom_range(0, 1));
        d       = 8'($urandom);
        tick();
      end
      chk("d1_tokens", 3, int'((outcnt[3] - start) >= 2000), 1);
    end
    d_valid = 1'b0; q_bp = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    for (int i = 0; i < NI; i++) chk("final_empty", i, int'(cnt_w[i]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_fifo_param.md
Name: pipeline_fifo_param

Overview:
- Parametrised N-slot elastic pipeline buffer; next generation of the single/double-slot pipeline registers.
- Uses the same valid/backpressure (LI) handshake on both sides.
- Adds configurable depth, occupancy count, almost-full flag and an optional zero-latency bypass mode.
- Sits between LI pipeline stages wherever more than two tokens of slack are needed, e.g. around variable-latency units.

Parameters:
Width, 8, data bits per token (>=1)
Depth, 4, storage slots (1..256); Depth=1 gives half throughput, Depth>=2 gives full throughput
Bypass, 0, 1 = when empty, the input token is presented on q in the same cycle
AlmostFull, Depth-1, almost_full asserts when count >= AlmostFull (1..Depth)

Ports:
clk  in  1  clock; all state changes on posedge
resetn  in  1  synchronous reset, active-low
d  in  Width  input token data
d_valid  in  1  input token present
d_bp  out  1  backpressure to upstream; token not accepted while high
q  out  Width  output token data
q_valid  out  1  output token present
q_bp  in  1  backpressure from downstream
count  out  CW=$clog2(Depth+1)  tokens currently stored (excludes a bypassed token)
almost_full  out  1  count >= AlmostFull

Behaviour:
- Interface is one clock (clk) with synchronous, active-low reset (resetn).
- Reset: on a posedge with resetn=0, rd_ptr, wr_ptr and count go to 0. Storage data is not reset. After that edge: q_valid=0, d_bp=0, count=0, almost_full=0 (or 1 only if AlmostFull=0, which is illegal). Reset mid-operation discards all stored tokens.
- Handshake: a token transfers on a side in any cycle where valid=1 and bp=0.
  - incoming = d_valid & ~d_bp
  - outgoing = q_valid & ~q_bp
- d_bp = (count == Depth). It is purely registered; there is no combinational path from q_bp to d_bp. When full, no token is accepted even if one leaves that cycle.
- Storage: circular buffer of Depth entries. rd_ptr and wr_ptr wrap from Depth-1 to 0 explicitly, so non-power-of-two depths are supported.
- Bypass=0:
  - q = mem[rd_ptr]; q_valid = (count != 0).
  - Latency: a token accepted at edge N is visible on q at cycle N+1.
  - Push only: write mem[wr_ptr], wr_ptr++, count++.
  - Pop only: rd_ptr++, count--.
  - Push+pop: both pointers advance, count unchanged. Legal even at count=1; the write goes to wr_ptr and never collides with rd_ptr.
- Bypass=1:
  - If count==0: q = d and q_valid = d_valid (combinational).
    - d_valid & ~q_bp: token passes through; nothing is stored; count stays 0.
    - d_valid & q_bp: token is written to storage; count becomes 1.
  - If count!=0: behaves as Bypass=0, so ordering is preserved.
- Throughput:
  - Depth>=2: 1 token/cycle sustained when downstream never stalls.
  - Depth=1, Bypass=0: 1 token per 2 cycles.
- Boundaries:
  - Pop when empty is impossible (q_valid=0).
  - d_valid held high while full: token held upstream, d_bp=1, nothing lost.
  - count never exceeds Depth; count never underflows.
- Simulation-only assertions: count <= Depth; ~(incoming & full); q stable while q_valid & q_bp (no data change under stall).
- q contents are don't-care when q_valid=0.

Decomposition:
- Shared package pipeline_pkg holds a clog2 helper and LI handshake constants; no typedefs needed.
- One sub-module is natural: pipeline_wrap_ctr (parameter Depth; inputs clk, resetn, inc; output ptr). Instantiated twice, for rd_ptr and wr_ptr.
- count and flags live in the top module.

Test Plan:
- Depth=4, Bypass=0: push 0x11,0x22,0x33,0x44 with q_bp=1 -> count 1..4; d_bp=1 after the 4th edge; almost_full=1 at count=3; q=0x11 held stable.
- Then release q_bp=0 with d_valid=0 -> q sequence 0x11,0x22,0x33,0x44 on consecutive cycles; count 3,2,1,0; q_valid=0 afterwards; d_bp drops after the first pop edge.
- Depth=3 (non-power-of-two): stream 10 tokens 0..9 with q_bp=0 -> outputs 0..9 in order, one per cycle after 1-cycle latency; pointers wrap 2->0; count stays at 1.
- Bypass=1, empty, q_bp=0, d=0xA5 d_valid=1 -> q=0xA5, q_valid=1 in the same cycle; count stays 0. Repeat with q_bp=1 -> count becomes 1 and q=0xA5 is held next cycle.
- Reset mid-stream: count=3, assert resetn=0 for one edge -> count=0, q_valid=0, d_bp=0 after that edge; the next push 0x7E is the first token out.
- Random LI stress: random d_valid and q_bp at 50%, 2000 tokens, Depth in {1,2,5} -> scoreboard shows in-order, no loss, no duplication, no assertion fires; Depth=1 never exceeds 1 token per 2 cycles.
